config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_if.sv | 21 ++
 rtl/config_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Host word stream into the loader and the broadcast configuration bus out to the tiles.
interface config_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;

  modport master (
    output in_valid, in_addr, in_data, in_last,
    input  in_ready, config_addr, config_data, config_en
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_last,
    output in_ready, config_addr, config_data, config_en
  );
endinterface

// File: rtl/config_loader.sv
// Buffers (addr, data) words from a host in a small FIFO and broadcasts them one per
// cycle onto the tile configuration bus, honouring tile back-pressure (hold).
module config_loader #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  config_loader_if.slave     bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        word_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [31:0]     cfg_addr_q, cfg_data_q;
  logic            cfg_en_q;
  logic [15:0]     wcnt_q;

  logic full, empty, active, push, pop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign active = (state_q == LOAD) || (state_q == DRAIN);
  // in_ready comes from registered occupancy only, so a full FIFO never bypasses.
  assign bus.in_ready = (state_q == LOAD) && !full;
  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = active && !empty && !hold;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (push && bus.in_last) state_d = DRAIN;
      DRAIN:   if (empty && !cfg_en_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      cfg_en_q   <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      cfg_en_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        cfg_addr_q <= mem_q[rd_ptr_q][63:32];
        cfg_data_q <= mem_q[rd_ptr_q][31:0];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (state_q == IDLE && start) wcnt_q <= '0;
      else if (pop)                 wcnt_q <= sat_inc(wcnt_q);
    end
  end

  // Storage is not reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
  end

  assign bus.config_addr = cfg_addr_q;
  assign bus.config_data = cfg_data_q;
  assign bus.config_en   = cfg_en_q;
  assign busy            = active;
  assign done            = (state_q == DONE);
  assign word_count      = wcnt_q;

endmodule
